// File: rtl/dice_pkg.sv
// dice_pkg: shared encodings and constants for the craps judge.
//   phase_e   : game phase as seen on the phase output
//   DIE_*     : legal face range of one die
//   SUM_*     : come-out naturals and craps
//   die_ok()  : 1 when a die value is a legal face
package dice_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_COME_OUT = 2'd1,
    PH_POINT    = 2'd2,
    PH_DONE     = 2'd3
  } phase_e;

  localparam logic [3:0] DIE_MIN    = 4'd1;
  localparam logic [3:0] DIE_MAX    = 4'd6;
  localparam logic [3:0] SUM_NAT7   = 4'd7;
  localparam logic [3:0] SUM_NAT11  = 4'd11;
  localparam logic [3:0] SUM_CRAP2  = 4'd2;
  localparam logic [3:0] SUM_CRAP3  = 4'd3;
  localparam logic [3:0] SUM_CRAP12 = 4'd12;

  function automatic logic die_ok(input logic [3:0] d);
    return (d >= DIE_MIN) && (d <= DIE_MAX);
  endfunction

endpackage

// File: rtl/dice_roll_sampler.sv
// dice_roll_sampler: turns the keyf falling edge into a one-cycle sample
// strobe delayed by one clock, so num2 (updated by the dice stage on the
// fall) is stable when read, and classifies the sampled dice.
//   clk, rst    : clock, synchronous active-high reset
//   keyf_i      : roll button (debounced)
//   num1, num2  : dice values from the dice stage
//   sample_ok   : strobe, both dice in 1..6
//   roll_err    : strobe, at least one die out of range
module dice_roll_sampler
  import dice_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       keyf,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  output logic       sample_ok,
  output logic       roll_err
);

  logic keyf_q, keyf_d;
  logic sample_p_q, sample_p_d;
  logic dice_ok;

  // A new fall re-arms the strobe even when it is already set, so
  // back-to-back falls each produce exactly one sample.
  assign keyf_d     = keyf;
  assign sample_p_d = keyf_q & ~keyf;

  always_ff @(posedge clk) begin
    if (rst) begin
      keyf_q     <= 1'b0;
      sample_p_q <= 1'b0;
    end else begin
      keyf_q     <= keyf_d;
      sample_p_q <= sample_p_d;
    end
  end

  assign dice_ok   = die_ok(num1) & die_ok(num2);
  assign sample_ok = sample_p_q &  dice_ok;
  assign roll_err  = sample_p_q & ~dice_ok;

endmodule

// File: rtl/dice_judge.sv
// dice_judge: craps scoring for the two dice from the dice stage.
//   clk, rst           : clock, synchronous active-high reset
//   keyf, clr          : roll / new-game buttons shared with the dice stage
//   num1, num2         : dice values (1..6 valid)
//   sum, point, phase  : last valid sum, current point, game phase
//   win, lose          : game result levels, held in DONE
//   roll_err           : one-cycle pulse on an out-of-range sample
//   roll_cnt           : valid rolls this game
//   win_cnt, lose_cnt  : games won / lost since reset (saturating)
module dice_judge
  import dice_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             keyf,
  input  logic             clr,
  input  logic [3:0]       num1,
  input  logic [3:0]       num2,
  output logic [3:0]       sum,
  output logic [3:0]       point,
  output logic [1:0]       phase,
  output logic             win,
  output logic             lose,
  output logic             roll_err,
  output logic [CNT_W-1:0] roll_cnt,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] lose_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic       sample_ok, sample_err;
  logic [3:0] roll_sum;

  phase_e           phase_q, phase_d;
  logic [3:0]       sum_q, sum_d, point_q, point_d;
  logic             win_q, win_d, lose_q, lose_d, err_q, err_d;
  logic [CNT_W-1:0] roll_q, roll_d, wins_q, wins_d, losses_q, losses_d;

  dice_roll_sampler u_sampler (
    .clk       (clk),
    .rst       (rst),
    .keyf      (keyf),
    .num1      (num1),
    .num2      (num2),
    .sample_ok (sample_ok),
    .roll_err  (sample_err)
  );

  // Only used on valid samples (2..12), so 4 bits never overflow.
  assign roll_sum = num1 + num2;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_IDLE;
      sum_q    <= '0;
      point_q  <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      err_q    <= 1'b0;
      roll_q   <= '0;
      wins_q   <= '0;
      losses_q <= '0;
    end else begin
      phase_q  <= phase_d;
      sum_q    <= sum_d;
      point_q  <= point_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      err_q    <= err_d;
      roll_q   <= roll_d;
      wins_q   <= wins_d;
      losses_q <= losses_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    sum_d    = sum_q;
    point_d  = point_q;
    win_d    = win_q;
    lose_d   = lose_q;
    err_d    = sample_err;
    roll_d   = roll_q;
    wins_d   = wins_q;
    losses_d = losses_q;

    unique case (phase_q)
      PH_IDLE, PH_DONE: begin
        // Samples are dropped here; clr starts a fresh game.
        if (clr) begin
          phase_d = PH_COME_OUT;
          sum_d   = '0;
          point_d = '0;
          roll_d  = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
        end
      end
      PH_COME_OUT, PH_POINT: begin
        // clr only re-arms the dice stage mid-game, so it is not looked at.
        if (sample_ok) begin
          sum_d  = roll_sum;
          roll_d = (&roll_q) ? roll_q : roll_q + ONE;
          if (phase_q == PH_COME_OUT) begin
            if (roll_sum == SUM_NAT7 || roll_sum == SUM_NAT11) begin
              phase_d = PH_DONE;
              win_d   = 1'b1;
            end else if (roll_sum == SUM_CRAP2 || roll_sum == SUM_CRAP3 ||
                         roll_sum == SUM_CRAP12) begin
              phase_d = PH_DONE;
              lose_d  = 1'b1;
            end else begin
              phase_d = PH_POINT;
              point_d = roll_sum;
            end
          end else if (roll_sum == point_q) begin
            phase_d = PH_DONE;
            win_d   = 1'b1;
          end else if (roll_sum == SUM_NAT7) begin
            phase_d = PH_DONE;
            lose_d  = 1'b1;
          end
          if (win_d && !win_q)
            wins_d = (&wins_q) ? wins_q : wins_q + ONE;
          if (lose_d && !lose_q)
            losses_d = (&losses_q) ? losses_q : losses_q + ONE;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign sum      = sum_q;
  assign point    = point_q;
  assign phase    = phase_q;
  assign win      = win_q;
  assign lose     = lose_q;
  assign roll_err = err_q;
  assign roll_cnt = roll_q;
  assign win_cnt  = wins_q;
  assign lose_cnt = losses_q;

endmodule

// File: tb/tb_dice_judge.sv
// Bench for dice_judge: two instances (CNT_W=8 and CNT_W=2) share one
// stimulus stream; a cycle-level craps model predicts every output.
module tb_dice_judge;

  logic       clk = 1'b0;
  logic       rst, keyf, clr;
  logic [3:0] num1, num2;

  logic [3:0] sum8, point8, sum2, point2;
  logic [1:0] phase8, phase2;
  logic       win8, lose8, err8, win2, lose2, err2;
  logic [7:0] roll8, wins8, losses8;
  logic [1:0] roll2, wins2, losses2;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int m_phase, m_sum, m_point, m_win, m_lose, m_err;
  int m_roll, m_wins, m_losses;
  bit m_pend, m_prevk;

  always #5 clk = ~clk;

  dice_judge #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .keyf(keyf), .clr(clr), .num1(num1), .num2(num2),
    .sum(sum8), .point(point8), .phase(phase8), .win(win8), .lose(lose8),
    .roll_err(err8), .roll_cnt(roll8), .win_cnt(wins8), .lose_cnt(losses8)
  );

  dice_judge #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .keyf(keyf), .clr(clr), .num1(num1), .num2(num2),
    .sum(sum2), .point(point2), .phase(phase2), .win(win2), .lose(lose2),
    .roll_err(err2), .roll_cnt(roll2), .win_cnt(wins2), .lose_cnt(losses2)
  );

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Game rules applied to whatever the inputs are at the coming edge.
  task automatic model_edge();
    bit newpend, valid;
    int s;
    if (rst) begin
      m_phase = 0; m_sum = 0; m_point = 0; m_win = 0; m_lose = 0;
      m_err = 0; m_roll = 0; m_wins = 0; m_losses = 0;
      m_pend = 0; m_prevk = 0;
      return;
    end
    newpend = m_prevk && !keyf;
    valid = (num1 >= 1 && num1 <= 6 && num2 >= 1 && num2 <= 6);
    m_err = (m_pend && !valid) ? 1 : 0;
    if (m_phase == 0 || m_phase == 3) begin
      if (clr) begin
        m_phase = 1; m_sum = 0; m_point = 0; m_roll = 0;
        m_win = 0; m_lose = 0;
      end
    end else if (m_pend && valid) begin
      s = int'(num1) + int'(num2);
      m_sum = s;
      m_roll++;
      if (m_phase == 1) begin
        if (s == 7 || s == 11) begin m_phase = 3; m_win = 1; m_wins++; end
        else if (s == 2 || s == 3 || s == 12) begin
          m_phase = 3; m_lose = 1; m_losses++;
        end else begin m_phase = 2; m_point = s; end
      end else begin
        if (s == m_point) begin m_phase = 3; m_win = 1; m_wins++; end
        else if (s == 7) begin m_phase = 3; m_lose = 1; m_losses++; end
      end
    end
    m_pend = newpend;
    m_prevk = keyf;
  endtask

  task automatic check_all();
    chk("phase8", phase8, m_phase);   chk("phase2", phase2, m_phase);
    chk("sum8", sum8, m_sum);         chk("sum2", sum2, m_sum);
    chk("point8", point8, m_point);   chk("point2", point2, m_point);
    chk("win8", win8, m_win);         chk("win2", win2, m_win);
    chk("lose8", lose8, m_lose);      chk("lose2", lose2, m_lose);
    chk("err8", err8, m_err);         chk("err2", err2, m_err);
    chk("roll8", roll8, clampv(m_roll, 255));
    chk("roll2", roll2, clampv(m_roll, 3));
    chk("wins8", wins8, clampv(m_wins, 255));
    chk("wins2", wins2, clampv(m_wins, 3));
    chk("losses8", losses8, clampv(m_losses, 255));
    chk("losses2", losses2, clampv(m_losses, 3));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // keyf falls with the given dice; returns when the result is visible.
  task automatic roll(input int d1, input int d2, input bit c);
    num1 = 4'(d1); num2 = 4'(d2); clr = c; keyf = 1'b0;
    cyc(); cyc();
  endtask

  task automatic release_key();
    keyf = 1'b1; clr = 1'b0;
    cyc();
  endtask

  task automatic new_game();
    clr = 1'b1; cyc(); clr = 1'b0; cyc();
  endtask

  initial begin
    rst = 1'b1; keyf = 1'b1; clr = 1'b0; num1 = '0; num2 = '0;
    model_edge();
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();
    chk("rst_phase", phase8, 0);
    chk("rst_wins", wins8, 0);

    // idle ignores rolls
    roll(3, 4, 0);
    chk("idle_phase", phase8, 0);
    chk("idle_sum", sum8, 0);
    release_key();

    // natural 11
    new_game();
    chk("clr_phase", phase8, 1);
    roll(5, 6, 0);
    chk("nat_phase", phase8, 3);
    chk("nat_sum", sum8, 11);
    chk("nat_win", win8, 1);
    chk("nat_wins", wins8, 1);
    chk("nat_roll", roll8, 1);
    release_key();

    // point 4 made, with clr held during mid-game rolls
    new_game();
    roll(2, 2, 0);
    chk("pt_phase", phase8, 2);
    chk("pt_point", point8, 4);
    release_key();
    roll(1, 5, 1);
    chk("pt_stay", phase8, 2);
    chk("pt_roll2", roll8, 2);
    release_key();
    roll(3, 1, 1);
    chk("pt_win", win8, 1);
    chk("pt_roll3", roll8, 3);
    release_key();

    // seven-out on point 6
    new_game();
    roll(3, 3, 0);
    chk("so_point", point8, 6);
    release_key();
    roll(3, 4, 0);
    chk("so_lose", lose8, 1);
    chk("so_losses", losses8, 1);
    chk("so_point_held", point8, 6);
    release_key();

    // craps 12, then out-of-range die
    new_game();
    roll(6, 6, 0);
    chk("craps_lose", lose8, 1);
    release_key();
    new_game();
    roll(0, 5, 0);
    chk("bad_err", err8, 1);
    chk("bad_phase", phase8, 1);
    chk("bad_roll", roll8, 0);
    release_key();
    chk("bad_err_pulse", err8, 0);

    // wins 3 and 4: the 2-bit counter sticks at 3
    new_game(); roll(5, 2, 0); release_key();
    new_game(); roll(6, 5, 0); release_key();
    chk("sat_wins2", wins2, 3);
    chk("sat_wins8", wins8, 4);
    new_game(); roll(4, 3, 0); release_key();
    chk("sat_hold2", wins2, 3);

    // reset mid-game
    new_game();
    roll(4, 4, 0);
    chk("mid_phase", phase8, 2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_phase", phase8, 0);
    chk("mid_rst_point", point8, 0);
    chk("mid_rst_wins", wins8, 0);
    release_key();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) keyf = ~keyf;
      clr  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0) begin
        num1 = 4'($urandom_range(0, 15));
        num2 = 4'($urandom_range(0, 15));
      end else begin
        num1 = 4'($urandom_range(1, 6));
        num2 = 4'($urandom_range(1, 6));
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
